// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture bridge: register offsets inside
// the 32-byte window, CTRL bit positions, capture FSM states and the STATUS
// register layout.
package cam_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFS_W  = 5;
  localparam int unsigned FRM_W  = 16;

  localparam logic [OFS_W-1:0] CTRL_OFS   = 5'h00;
  localparam logic [OFS_W-1:0] STATUS_OFS = 5'h04;
  localparam logic [OFS_W-1:0] DATA_OFS   = 5'h08;
  localparam logic [OFS_W-1:0] POP_OFS    = 5'h0C;
  localparam logic [OFS_W-1:0] FRAMES_OFS = 5'h10;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLR    = 2;

  typedef enum logic [1:0] {IDLE, WAIT_VS, SYNC, CAPTURE} cap_state_t;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  count;
    logic [4:0]  rsvd_lo;
    logic        ovf;
    logic        full;
    logic        empty;
  } status_t;

endpackage

// File: rtl/word_fifo.sv
// Word FIFO with occupancy count.
// Ports: push/pop strobes (pop ignored when empty, push ignored when full
// unless a pop happens in the same cycle), clr empties the FIFO, din/dout
// data, empty/full flags and count (0..DEPTH). Synchronous active-low reset.
module word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cam_mmio.sv
// Memory-mapped camera capture bridge on the CPU data port.
// Ports: clk, reset (sync, active-low); CPU side addr/wdata/we -> rdata;
// RAM side ram_we/ram_rdata for addresses outside the register window;
// camera side cam_vsync/cam_href/cam_valid/cam_data; irq when enabled and
// the FIFO holds data. Camera bytes are packed little-endian into words.
module cam_mmio
  import cam_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int unsigned DEPTH     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              cam_valid,
  input  logic [7:0]        cam_data,
  output logic              irq
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic              in_window;
  logic [OFS_W-1:0]  ofs;
  logic              wr_ctrl;
  logic              pop_req;
  logic              clr_c;
  logic              byte_c;
  logic              push_c;
  logic              ctrl_en;
  logic              ctrl_irq_en;
  logic              ovf;
  logic [FRM_W-1:0]  frames;
  cap_state_t        state;
  logic [1:0]        idx;
  logic [3:0][7:0]   word;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW-1:0]     fifo_count;
  status_t           status;
  logic              unused_wdata;

  assign unused_wdata = ^wdata[DATA_W-1:CTRL_CLR+1];

  // Address decode and store strobes.
  assign in_window = (addr[ADDR_W-1:OFS_W] == BASE_ADDR[ADDR_W-1:OFS_W]);
  assign ofs       = addr[OFS_W-1:0];
  assign ram_we    = we & ~in_window;
  assign wr_ctrl   = we & in_window & (ofs == CTRL_OFS);
  assign pop_req   = we & in_window & (ofs == POP_OFS);
  assign clr_c     = wr_ctrl & wdata[CTRL_CLR];

  // A byte is taken only mid-frame; vsync high ends the frame instead.
  assign byte_c = (state == CAPTURE) & ctrl_en & ~cam_vsync & cam_href & cam_valid;
  assign push_c = byte_c & (idx == 2'd3) & ~clr_c;

  assign irq = ctrl_irq_en & ~fifo_empty;

  word_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_req),
    .clr   (clr_c),
    .din   ({cam_data, word[2:0]}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Control register, overflow flag, frame counter, packer and capture FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ovf         <= 1'b0;
      frames      <= '0;
      state       <= IDLE;
      idx         <= '0;
      word        <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= wdata[CTRL_EN];
        ctrl_irq_en <= wdata[CTRL_IRQ_EN];
      end

      // A concurrent pop makes room, so only an unrelieved full push overflows.
      if (clr_c) ovf <= 1'b0;
      else if (push_c & fifo_full & ~pop_req) ovf <= 1'b1;

      if (!ctrl_en) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        case (state)
          IDLE:    state <= WAIT_VS;
          WAIT_VS: if (cam_vsync) state <= SYNC;
          SYNC: begin
            if (!cam_vsync) begin
              state <= CAPTURE;
              idx   <= '0;
            end
          end
          CAPTURE: begin
            if (cam_vsync) begin
              frames <= frames + FRM_W'(1);
              idx    <= '0;
              state  <= SYNC;
            end else if (byte_c) begin
              word[idx] <= cam_data;
              idx       <= idx + 2'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Clear overrides any frame count or byte index update this cycle.
      if (clr_c) begin
        frames <= '0;
        idx    <= '0;
      end
    end
  end

  // Status word assembly.
  always_comb begin
    status       = '0;
    status.count = 8'(fifo_count);
    status.ovf   = ovf;
    status.full  = fifo_full;
    status.empty = fifo_empty;
  end

  // Combinational read mux: registers inside the window, RAM elsewhere.
  always_comb begin
    rdata = ram_rdata;
    if (in_window) begin
      case (ofs)
        CTRL_OFS:   rdata = {29'b0, 1'b0, ctrl_irq_en, ctrl_en};
        STATUS_OFS: rdata = status;
        DATA_OFS:   rdata = fifo_empty ? '0 : fifo_dout;
        FRAMES_OFS: rdata = {16'b0, frames};
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/cam_mmio.md
# cam_mmio

Memory-mapped camera capture bridge that sits directly downstream of the `arm` core's memory port. It consumes `ALUResult` (address), `WriteData` and `write_enable`, and returns `ReadData`. A fixed address window is decoded into capture registers. Within that window, a camera byte stream is packed into 32-bit words and buffered in a FIFO for software to read. All other addresses pass through to the data RAM.

## Interface
- `BASE_ADDR`, default `32'hFFFF_0000`: base of the 32-byte register window; decode is on `addr[31:5]`.
- `DEPTH`, default `16`: FIFO depth in words; must be a power of 2 and at least 2.
- `clk` input 1: the single clock.
- `reset` input 1: synchronous, active-low.
- `addr` input 32: CPU address (`ALUResult`).
- `wdata` input 32: CPU store data (`WriteData`).
- `we` input 1: CPU store strobe (`write_enable`).
- `rdata` output 32: CPU load data (`ReadData`).
- `ram_we` output 1: RAM write strobe; equals `we & ~in_window`.
- `ram_rdata` input 32: RAM read data.
- `cam_vsync` input 1: frame sync; high between frames.
- `cam_href` input 1: line valid.
- `cam_valid` input 1: byte strobe, qualified by `cam_href`.
- `cam_data` input 8: pixel byte.
- `irq` output 1: high when `ctrl.irq_en & ~empty`.

## Operation
Register map, by byte offset:
- `0x00` CTRL (R/W)
  - bit0 `en`
  - bit1 `irq_en`
  - bit2 `clr`: write-1 pulse, self-clearing, reads 0.
- `0x04` STATUS (RO)
  - bit0 `empty`, bit1 `full`, bit2 `ovf` (sticky).
  - bits[15:8] `count`.
- `0x08` DATA (RO): FIFO head word, non-destructive read; reads 0 when empty.
- `0x0C` POP (WO): any store advances the FIFO head. Ignored when empty.
- `0x10` FRAMES (RO): 16-bit completed-frame counter, zero-extended; wraps `0xFFFF`→0.
- Unmapped window offsets read 0 and ignore writes.

Read path:
- `rdata` is combinational: register mux when `in_window`, else `ram_rdata`.

Capture FSM:
- IDLE
  - `en=1` → WAIT_VS.
- WAIT_VS
  - Wait for `cam_vsync=1`, then → SYNC.
  - Guarantees capture never starts mid-frame.
- SYNC
  - `cam_vsync=0` → CAPTURE; byte index cleared.
- CAPTURE
  - Each cycle with `cam_href & cam_valid`, `cam_data` goes into the current word at byte `idx`: byte0→[7:0] … byte3→[31:24]; `idx` increments.
  - When `idx=3` the word is pushed in the same cycle and `idx` returns to 0.
  - `cam_vsync=1` → `FRAMES`+1, partial word discarded, → SYNC.
- Any state
  - `en=0` → IDLE next cycle; partial word discarded; FIFO contents kept.

Boundary rules:
- Push while full: word dropped and `ovf` set. If pop and push occur in the same cycle while full, both occur and `ovf` is not set.
- Pop while empty: no effect.
- Simultaneous pop and push with 0<count<DEPTH: count unchanged.
- `clr`: FIFO empty, `ovf`=0, `FRAMES`=0, `idx`=0. FSM state kept.
  - A push in the same cycle as `clr` is dropped.
- `count` saturates structurally at DEPTH; there is no wrap.

## Timing
- Reset (`reset=0` at a clock edge):
  - CTRL=0, FSM=IDLE, FIFO empty, `ovf`=0, `FRAMES`=0, `idx`=0.
  - `irq`=0; `ram_we` follows `we` combinationally.
  - Reset asserted mid-frame aborts capture immediately.
- CPU store to a register takes effect at the same clock edge.
- Camera byte to DATA visibility: the 4th byte of a word is sampled at edge N; `empty`=0 and DATA are valid after edge N, so a same-cycle CPU read sees them in cycle N+1.
- POP store at edge N: new head is visible after edge N.
- `en` write at edge N: FSM leaves IDLE at edge N+1.

## Structure
- `cam_pkg`:
  - Register offsets `CTRL_OFS`, `STATUS_OFS`, `DATA_OFS`, `POP_OFS`, `FRAMES_OFS`.
  - CTRL bit indices.
  - `cap_state_t` enum {IDLE, WAIT_VS, SYNC, CAPTURE}.
- Sub-module `word_fifo`:
  - Parameters: WIDTH, DEPTH.
  - Ports: `push`, `pop`, `clr`, `din`, `dout`, `empty`, `full`, `count`.
  - Synchronous, same reset.
- `cam_mmio` contains the decode, register file, packer and FSM.

## Test plan
- Reset mid-operation: hold `reset=0` for one edge during CAPTURE with 2 words queued → STATUS reads `0x0000_0001`, FRAMES=0, `irq`=0.
- Pass-through: store `0x1234_5678` to address `0x0000_0040` → `ram_we`=1, no register change; load from `0x40` with `ram_rdata=0xCAFE_F00D` → `rdata=0xCAFE_F00D`.
- Packing and frame count:
  - Write CTRL=1, then `vsync` 1→0.
  - Send bytes `0x11,0x22,0x33,0x44,0x55`, then raise `vsync`.
  - Expect DATA=`0x4433_2211`, count=1, FRAMES=1; the partial word 0x55 is discarded.
- Mid-frame enable: set `en` while `vsync=0` and bytes are streaming → nothing captured until the next `vsync` high→low.
- Overflow (DEPTH=16):
  - Push 17 words with no pops → `full`=1, `ovf`=1, count=16.
  - Pop then DATA → the 2nd word.
  - Write CTRL=`0x5` → STATUS=`0x1`.
- Simultaneous events:
  - With FIFO full, a POP store in the same cycle as a 4th byte → count stays 16, `ovf` stays 0.
  - POP on an empty FIFO → count stays 0.
